// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter constants for the branch predictor
package bp_pkg;

  localparam int BP_XLEN = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [1:0]         ctr;
    logic [BP_XLEN-1:0] target;
  } bht_entry_t;

  typedef enum logic {
    IDLE,
    RECOVER
  } bp_state_e;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-value
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - direct-mapped BHT/BTB with registered redirect and flush; BP_STATS_EN adds counters
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int  XLEN        = BP_XLEN,
  parameter int  BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            ex_actual_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  bht_entry_t bht_q [BHT_ENTRIES];

  bp_state_e       state_q, state_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  bht_entry_t       rd_entry, ex_entry, upd_entry;
  logic [1:0]       ctr_next;
  logic             res, mispredict;
  logic [XLEN-1:0]  correct_pc;
  logic             unused_if_pc;

  assign if_idx       = if_pc[IDX_W+1:2];
  assign ex_idx       = ex_pc[IDX_W+1:2];
  assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle write is seen next cycle.
  assign rd_entry    = bht_q[if_idx];
  assign pred_taken  = rd_entry.valid & rd_entry.ctr[1];
  assign pred_target = rd_entry.target;

  assign res = ex_valid & (ex_is_branch | ex_is_jump) & (state_q == IDLE);
  assign mispredict = res & ((ex_actual_taken != ex_pred_taken) |
                             (ex_actual_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign correct_pc = ex_actual_taken ? ex_target : ex_pc + XLEN'(4);

  assign ex_entry = bht_q[ex_idx];

  sat_counter2 u_sat_counter2 (
    .ctr_i   (ex_entry.ctr),
    .taken_i (ex_actual_taken),
    .ctr_o   (ctr_next)
  );

  // A jump (including the illegal branch+jump combination) pins the counter at strongly taken.
  always_comb begin
    upd_entry     = ex_entry;
    upd_entry.ctr = ex_is_jump ? CTR_ST : ctr_next;
    if (ex_actual_taken) begin
      upd_entry.valid  = 1'b1;
      upd_entry.target = ex_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= '{valid: 1'b0, ctr: CTR_WNT, target: '0};
      end
    end else if (res) begin
      bht_q[ex_idx] <= upd_entry;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d       = RECOVER;
          redirect_d    = 1'b1;
          redirect_pc_d = correct_pc;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush_if_id = redirect_q;
  assign flush_id_ex = redirect_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (res)        stat_br_q <= stat_br_q + 32'd1;
      if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed self-checking bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_actual_taken;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int compared;
  int mismatched;

  branch_predict_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .ex_valid        (ex_valid),
    .ex_is_branch    (ex_is_branch),
    .ex_is_jump      (ex_is_jump),
    .ex_pc           (ex_pc),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .ex_actual_taken (ex_actual_taken),
    .ex_target       (ex_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                        input logic pt, input logic [31:0] ptg, input logic at, input logic [31:0] tg);
    ex_valid        = v;
    ex_is_branch    = br;
    ex_is_jump      = jp;
    ex_pc           = pc;
    ex_pred_taken   = pt;
    ex_pred_target  = ptg;
    ex_actual_taken = at;
    ex_target       = tg;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tg);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, exp_t});
    check({tag, "_target"}, pred_target, exp_tg);
  endtask

  task automatic expect_redirect(input string tag, input logic exp_r, input logic [31:0] exp_pc);
    check({tag, "_redirect"}, {31'b0, redirect}, {31'b0, exp_r});
    check({tag, "_flush_if_id"}, {31'b0, flush_if_id}, {31'b0, exp_r});
    check({tag, "_flush_id_ex"}, {31'b0, flush_id_ex}, {31'b0, exp_r});
    check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    if_pc      = 32'h0;
    idle_ex();
    repeat (2) step();
    reset = 1'b0;
    #1;

    expect_redirect("reset", 1'b0, 32'h0);
    lookup("reset_lookup", 32'h100, 1'b0, 32'h0);

    // First taken branch at 0x100, predicted not-taken; lookup in the same cycle sees the old entry
    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup("collide", 32'h100, 1'b0, 32'h0);
    step();
    idle_ex();
    expect_redirect("mp1", 1'b1, 32'h80);
    lookup("mp1_after", 32'h100, 1'b1, 32'h80);
    step();
    expect_redirect("mp1_clear", 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      step();
      check("taken_hit_redirect", {31'b0, redirect}, 32'h0);
    end
    idle_ex();

    // ctr 3 -> 2: still taken, but the not-taken outcome redirects to the fall-through
    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    step();
    idle_ex();
    expect_redirect("nt1", 1'b1, 32'h104);
    lookup("nt1_after", 32'h100, 1'b1, 32'h80);
    step();

    set_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    step();
    idle_ex();
    expect_redirect("nt2", 1'b1, 32'h104);
    lookup("nt2_after", 32'h100, 1'b0, 32'h80);
    step();

    // JAL at 0x200 aliases index 0; target mismatch with a taken prediction
    set_ex(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h340);
    step();
    idle_ex();
    expect_redirect("jal", 1'b1, 32'h340);
    lookup("jal_alias0", 32'h000, 1'b1, 32'h340);
    step();

    set_ex(1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 32'h340, 1'b0, 32'h0);
    step();
    idle_ex();
    expect_redirect("alias_nt", 1'b1, 32'h4);
    lookup("alias_100", 32'h100, 1'b1, 32'h340);
    step();

    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();

    // Wrong-path branch arriving in RECOVER must be ignored
    set_ex(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h44);
    step();
    expect_redirect("rec_first", 1'b1, 32'h44);
    set_ex(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 32'h99c);
    step();
    idle_ex();
    expect_redirect("rec_second", 1'b0, 32'h0);
    lookup("rec_no_update", 32'h20, 1'b0, 32'h0);
    lookup("rec_updated", 32'h10, 1'b1, 32'h44);
`ifdef BP_STATS_EN
    check("stat_branches", stat_branches, 32'd1);
    check("stat_mispredicts", stat_mispredicts, 32'd1);
`endif
    step();

    set_ex(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0, 32'h0);
    step();
    idle_ex();
    expect_redirect("wrap", 1'b1, 32'h0);
    lookup("wrap_entry", 32'hFFFF_FFFC, 1'b0, 32'h0);
    step();

    set_ex(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    check("novalid_redirect", {31'b0, redirect}, 32'h0);
    set_ex(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    check("nobranch_redirect", {31'b0, redirect}, 32'h0);
    idle_ex();
    lookup("unqualified_no_update", 32'h100, 1'b0, 32'h0);
    step();

    // Branch+jump together behaves as a jump: counter pinned at 3
    set_ex(1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 32'h500);
    step();
    idle_ex();
    expect_redirect("both", 1'b1, 32'h500);
    step();
    set_ex(1'b1, 1'b1, 1'b0, 32'h30, 1'b1, 32'h500, 1'b0, 32'h0);
    step();
    idle_ex();
    expect_redirect("both_nt", 1'b1, 32'h34);
    lookup("both_ctr2", 32'h30, 1'b1, 32'h500);
    step();

    set_ex(1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h60);
    step();
    idle_ex();
    check("midrst_pre_redirect", {31'b0, redirect}, 32'h1);
    reset = 1'b1;
    #1;
    expect_redirect("midrst", 1'b0, 32'h0);
    lookup("midrst_table", 32'h40, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    check("midrst_after", {31'b0, redirect}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Direct-mapped branch predictor and redirect/flush controller for the pipelined RV32I core.
- IF stage: looks up a 2-bit saturating counter plus a stored target, and produces a next-PC prediction.
- EX stage: compares the resolved outcome from the branch decision logic against the carried prediction.
- On mismatch: issues a registered PC redirect and IF/ID + ID/EX flush, and updates the table.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, table depth; power of two, minimum 2.
- IDX_W, $clog2(BHT_ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- if_pc  in  XLEN  PC of fetched instruction.
- pred_taken  out  1  IF prediction, combinational from table.
- pred_target  out  XLEN  predicted target; meaningful when pred_taken=1.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is JAL or JALR.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- ex_actual_taken  in  1  resolved pc_src from the branch decision logic.
- ex_target  in  XLEN  resolved target address.
- redirect  out  1  registered; PC mux selects redirect_pc.
- redirect_pc  out  XLEN  registered corrected PC.
- flush_if_id  out  1  registered; bubble IF/ID.
- flush_id_ex  out  1  registered; bubble ID/EX.

Behaviour:
- Index = pc[IDX_W+1:2]. No tag; aliasing accepted.
- Entry = {valid, ctr[1:0], target[XLEN-1:0]}.
- Reset (async, any time, including mid-recovery): all entries valid=0, ctr=2'b01, target=0; redirect, flush_*, redirect_pc=0; FSM->IDLE.
- Lookup (combinational, same cycle as if_pc): pred_taken = valid & ctr[1]; pred_target = target.
- Resolve qualifier: res = ex_valid & (ex_is_branch | ex_is_jump) & state==IDLE.
- mispredict = res & ((ex_actual_taken != ex_pred_taken) | (ex_actual_taken & ex_pred_taken & ex_target != ex_pred_target)).
- Correct PC = ex_actual_taken ? ex_target : ex_pc+4, 32-bit wrap (0xFFFFFFFC+4 -> 0).
- Table update on res, written at the clock edge:
  - Branch: ctr saturating +1 if taken, -1 if not; stays at 3 and at 0.
  - Jump: ctr=2'b11.
  - Target and valid=1 written only when ex_actual_taken=1.
  - Not-taken branch leaves target/valid unchanged.
- Read/write collision, same index in same cycle: lookup returns the old value (no bypass).
- FSM states:
  - IDLE: mispredict -> RECOVER. Registered redirect=flush_if_id=flush_id_ex=1 and redirect_pc = correct PC in the next cycle.
  - RECOVER: outputs high exactly 1 cycle, then -> IDLE and outputs 0. EX content in RECOVER is wrong-path: never resolved, never updates the table, never re-triggers.
- Latency:
  - Detection to redirect visible: 1 cycle.
  - Lookup: 0 cycles.
  - Table update visible to lookup: next cycle.
- ex_valid=0, or neither branch nor jump: no update, no redirect.
- ex_is_branch and ex_is_jump both 1: illegal; treated as jump.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds output stat_branches [31:0]: +1 per res.
  - Adds output stat_mispredicts [31:0]: +1 per mispredict.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package bp_pkg:
  - typedef bht_entry_t (packed valid/ctr/target).
  - typedef bp_state_e {IDLE, RECOVER}.
  - Constants CTR_WNT=2'b01, CTR_ST=2'b11, CTR_SNT=2'b00.
- Sub-module sat_counter2: combinational 2-bit saturating next-value from (ctr, taken).
- Table storage and FSM live in the top module.

Test Plan:
- Reset, then lookup if_pc=0x100 -> pred_taken=0, pred_target=0. Mid-recovery reset -> redirect drops immediately.
- Branch at 0x100 resolves taken, target 0x80, pred=0:
  - next cycle redirect=1, redirect_pc=0x80, both flushes=1 for exactly 1 cycle.
  - then lookup 0x100 -> pred_taken=1, pred_target=0x80.
- Same branch taken 3 more times -> ctr saturates at 3. One not-taken -> ctr=2, still predicts taken. That not-taken resolve also redirects to 0x104.
- JAL at 0x200, pred_taken=1, ex_pred_target=0x300, actual target 0x340 -> target mismatch: redirect to 0x340, entry target updated to 0x340.
- Mispredict at cycle N with another branch in EX at N+1 (RECOVER): no second redirect, no table change. With BP_STATS_EN: stat_branches=1, stat_mispredicts=1.
- Aliasing: PCs 0x000 and 0x100 with BHT_ENTRIES=64 share index 0; update via one is observed by the other. Same-cycle update and lookup of index 0 returns the pre-update value.
